// File: rtl/heater_pkg.sv
// Shared definitions for the heater PWM driver: FSM state encoding, duty range
// derivation and the signed-response to duty-count arithmetic.
package heater_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } heater_state_e;

  function automatic int duty_max(input int period_bits);
    return (1 << period_bits) - 1;
  endfunction

  // One response LSB (1/16 degC) equals one duty count; negatives switch off.
  function automatic int clamp_duty(input int resp, input int period_bits);
    int dmax;
    dmax = duty_max(period_bits);
    if (resp <= 0) return 0;
    if (resp > dmax) return dmax;
    return resp;
  endfunction

  function automatic int slew_toward(input int cur, input int tgt, input int step);
    if (tgt > cur + step) return cur + step;
    if (tgt < cur - step) return cur - step;
    return tgt;
  endfunction

endpackage

// File: rtl/heater_watchdog.sv
// Sample watchdog: counts PWM wraps since the last captured PID sample and
// flags expiry on the wrap that completes TIMEOUT_PERIODS silent periods.
module heater_watchdog #(
  parameter int TIMEOUT_PERIODS = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic wrap,
  input  logic capture,
  input  logic clear,
  output logic expired
);

  localparam int            CW        = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [CW-1:0] LAST_WRAP = CW'(TIMEOUT_PERIODS - 1);
  localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT_PERIODS);

  logic [CW-1:0] wraps_q, wraps_d;

  // A capture on the expiring wrap restarts the count rather than tripping.
  assign expired = wrap && !capture && !clear && (wraps_q == LAST_WRAP);

  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    wraps_d = wraps_q;
    if (clear || capture) begin
      wraps_d = '0;
    end else if (wrap && (wraps_q < LIMIT)) begin
      wraps_d = wraps_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) begin
      wraps_q <= '0;
    end else begin
      wraps_q <= wraps_d;
    end
  end

endmodule

// File: rtl/heater_pwm_driver.sv
// Heater element PWM stage: captures clamped PID samples, drives a fixed-period
// PWM and trips a latched fault when samples stop. Define HEATER_PWM_SOFTSTART_EN
// to slew the active duty by at most SLEW_STEP per period.
module heater_pwm_driver
  import heater_pkg::*;
#(
  parameter int WIDTH           = 12,
  parameter int PERIOD_BITS     = 8,
  parameter int TIMEOUT_PERIODS = 16,
  parameter int SLEW_STEP       = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       response,
  input  logic                   computed,
  output logic                   heater_on,
  output logic [PERIOD_BITS-1:0] duty,
  output logic                   period_start,
  output logic                   fault
);

  localparam logic [PERIOD_BITS-1:0] DUTY_MAX = PERIOD_BITS'(duty_max(PERIOD_BITS));

`ifdef HEATER_PWM_SOFTSTART_EN
  localparam bit SOFTSTART = 1'b1;
`else
  localparam bit SOFTSTART = 1'b0;
`endif

  // Without soft-start the step limit spans the whole range, so the duty jumps.
  localparam int STEP_LIMIT = SOFTSTART ? SLEW_STEP : duty_max(PERIOD_BITS) + 1;

  heater_state_e          state_q, state_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [PERIOD_BITS-1:0] duty_q, duty_d;
  logic [PERIOD_BITS-1:0] pending_q, pending_d;
  logic                   computed_q;
  logic                   heater_on_q, heater_on_d;
  logic                   period_start_q, period_start_d;
  logic                   fault_q, fault_d;

  int                     resp_ext;
  logic [PERIOD_BITS-1:0] mapped_duty;
  logic                   capture;
  logic                   wrap;
  logic                   wd_clear;
  logic                   wd_expired;

  assign resp_ext    = int'($signed(response));
  assign mapped_duty = PERIOD_BITS'(clamp_duty(resp_ext, PERIOD_BITS));
  assign capture     = computed && !computed_q;
  assign wrap        = (state_q == RUN) && (cnt_q == DUTY_MAX);
  assign wd_clear    = (state_q != RUN);

  heater_watchdog #(
    .TIMEOUT_PERIODS(TIMEOUT_PERIODS)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .wrap   (wrap),
    .capture(capture),
    .clear  (wd_clear),
    .expired(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    // A capture on the wrap cycle feeds the new duty straight into the next period.
    pending_d   = capture ? mapped_duty : pending_q;
    heater_on_d = (state_q == RUN) && (cnt_q < duty_q);

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        duty_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          duty_d  = '0;
        end else if (wd_expired) begin
          state_d = FAULT;
          cnt_d   = '0;
          duty_d  = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_BITS'(1);
          if (wrap) begin
            duty_d = PERIOD_BITS'(slew_toward(int'(duty_q), int'(pending_d), STEP_LIMIT));
          end
        end
      end
      FAULT: begin
        cnt_d  = '0;
        duty_d = '0;
        if (!enable) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        duty_d  = '0;
      end
    endcase

    period_start_d = (state_d == RUN) && (cnt_d == '0);
    fault_d        = (state_d == FAULT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      duty_q         <= '0;
      pending_q      <= '0;
      computed_q     <= 1'b0;
      heater_on_q    <= 1'b0;
      period_start_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      computed_q     <= computed;
      heater_on_q    <= heater_on_d;
      period_start_q <= period_start_d;
      fault_q        <= fault_d;
    end
  end

  assign heater_on    = heater_on_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_heater_pwm_driver.sv
// Randomized self-checking bench for heater_pwm_driver against a period-level
// reference model of capture, duty clamping, watchdog and state rules.
module tb_heater_pwm_driver;

  localparam int W    = 12;
  localparam int PB   = 8;
  localparam int TO   = 16;
  localparam int SLEW = 8;
  localparam int DMAX = (1 << PB) - 1;

  logic          CLK      = 1'b0;
  logic          nRST     = 1'b1;
  logic          enable   = 1'b0;
  logic          computed = 1'b0;
  logic [W-1:0]  response = '0;
  logic          heater_on;
  logic [PB-1:0] duty;
  logic          period_start;
  logic          fault;

  int total = 0;
  int bad   = 0;

  typedef enum int {M_IDLE, M_RUN, M_FAULT} mstate_t;
  mstate_t st_m      = M_IDLE;
  int      phase     = 0;
  int      duty_m    = 0;
  int      pend_m    = 0;
  int      wd_m      = 0;
  int      hi        = 0;
  int      extra     = 0;
  logic    prev_comp = 1'b0;

  heater_pwm_driver #(
    .WIDTH          (W),
    .PERIOD_BITS    (PB),
    .TIMEOUT_PERIODS(TO),
    .SLEW_STEP      (SLEW)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .enable      (enable),
    .response    (response),
    .computed    (computed),
    .heater_on   (heater_on),
    .duty        (duty),
    .period_start(period_start),
    .fault       (fault)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: run still active, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_ref(input logic [W-1:0] r);
    int v;
    v = int'($signed(r));
    if (v <= 0) return 0;
    if (v > DMAX) return DMAX;
    return v;
  endfunction

  function automatic int next_duty(input int cur, input int tgt);
`ifdef HEATER_PWM_SOFTSTART_EN
    if (tgt - cur > SLEW) return cur + SLEW;
    if (cur - tgt > SLEW) return cur - SLEW;
    return tgt;
`else
    if (cur < 0) return 0;
    return tgt;
`endif
  endfunction

  // Apply the inputs currently driven to the model, clock once, then observe.
  task automatic tick();
    logic cap;
    cap       = computed && !prev_comp;
    prev_comp = computed;
    if (cap) pend_m = clamp_ref(response);
    case (st_m)
      M_IDLE: if (enable) begin
        st_m = M_RUN; phase = 0; duty_m = 0; wd_m = 0; hi = 0; extra = 0;
      end
      M_RUN: begin
        if (!enable) begin
          st_m = M_IDLE;
        end else if (phase == DMAX) begin
          if (!cap && wd_m == TO - 1) begin
            st_m = M_FAULT;
          end else begin
            phase = 0; hi = 0; extra = 0;
            wd_m   = cap ? 0 : wd_m + 1;
            duty_m = next_duty(duty_m, pend_m);
          end
        end else begin
          phase++;
          if (cap) wd_m = 0;
        end
      end
      M_FAULT: if (!enable) st_m = M_IDLE;
      default: st_m = M_IDLE;
    endcase
    @(posedge CLK);
    @(negedge CLK);
    if (st_m == M_RUN) begin
      if (heater_on) hi++;
      if (period_start && phase != 0) extra++;
      if (phase == 0) begin
        check("period_start", period_start, 1);
        check("duty", duty, duty_m);
        check("fault_run", fault, 0);
      end
      if (phase == DMAX) begin
        check("on_cycles", hi, duty_m);
        check("extra_period_start", extra, 0);
      end
    end
  endtask

  task automatic run_period(input logic [W-1:0] val, input int cap_phase, input int hold,
                            input bit do_cap);
    for (int i = 0; i <= DMAX; i++) begin
      if (do_cap && phase == cap_phase) begin
        computed = 1'b1;
        response = val;
      end else if (do_cap && phase > cap_phase && phase < cap_phase + hold) begin
        response = W'($urandom);
      end else begin
        computed = 1'b0;
      end
      tick();
    end
  endtask

  logic [W-1:0] dir_vals [10] = '{12'h080, 12'hF80, 12'h3F0, 12'h000, 12'h0FF,
                                  12'h100, 12'h001, 12'h800, 12'h7FF, 12'h050};

  initial begin
    int guard;
    // reset state
    #2 nRST = 1'b0;
    #1;
    check("rst_heater", heater_on, 0);
    check("rst_duty", duty, 0);
    check("rst_period_start", period_start, 0);
    check("rst_fault", fault, 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    tick();
    check("idle_heater", heater_on, 0);
    check("idle_period_start", period_start, 0);

    // directed values, last one held high with a changing response
    enable = 1'b1;
    tick();
    foreach (dir_vals[k]) begin
      if (k == 9) run_period(dir_vals[k], 20, 30, 1'b1);
      else        run_period(dir_vals[k], $urandom_range(1, 254), 1, 1'b1);
    end

    // random samples, some on the wrap cycle, some held, some periods silent
    for (int p = 0; p < 14; p++) begin
      logic [W-1:0] v;
      int kind, cp, h;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       v = W'($urandom_range(2048, 4095));
        1:       v = W'($urandom_range(1, 255));
        2:       v = W'($urandom_range(256, 2047));
        default: v = W'($urandom);
      endcase
      cp = ($urandom_range(0, 3) == 0) ? DMAX : $urandom_range(1, DMAX);
      h  = $urandom_range(1, 4);
      if (h > DMAX + 1 - cp) h = DMAX + 1 - cp;
      run_period(v, cp, h, $urandom_range(0, 4) != 0);
    end
    run_period('0, 1, 1, 1'b0);

    // watchdog: a capture on the expiring wrap wins
    guard = 0;
    while (wd_m != TO - 1 && guard < 20) begin
      run_period('0, 1, 1, 1'b0);
      guard++;
    end
    run_period(12'h0A0, DMAX, 1, 1'b1);
    check("wd_capture_wins", fault, 0);

    // watchdog: silence until the fault trips
    computed = 1'b0;
    guard = 0;
    while (st_m != M_FAULT && guard < (TO + 2) * (DMAX + 1)) begin
      tick();
      guard++;
    end
    check("fault_set", fault, 1);
    check("fault_heater", heater_on, 0);

    // a sample in FAULT updates pending but does not clear the fault
    computed = 1'b1;
    response = 12'h040;
    tick();
    computed = 1'b0;
    repeat (5) tick();
    check("fault_hold", fault, 1);
    check("fault_hold_heater", heater_on, 0);

    enable = 1'b0;
    tick();
    check("fault_clear_idle", fault, 0);
    check("fault_clear_duty", duty, 0);
    check("fault_clear_ps", period_start, 0);
    enable = 1'b1;
    tick();
    run_period('0, 1, 1, 1'b0);

    // enable falling mid-period while the element is on
    while (phase != 5) tick();
    check("on_before_drop", heater_on, 1);
    enable = 1'b0;
    tick();
    check("drop_idle_duty", duty, 0);
    check("drop_idle_ps", period_start, 0);
    tick();
    check("drop_heater", heater_on, 0);

    // asynchronous reset mid-period with the element on
    enable = 1'b1;
    tick();
    run_period(12'h3F0, 10, 1, 1'b1);
    guard = 0;
    while (!heater_on && guard < 20) begin
      tick();
      guard++;
    end
    check("on_before_reset", heater_on, 1);
    #2 nRST = 1'b0;
    #1;
    check("async_heater", heater_on, 0);
    check("async_duty", duty, 0);
    check("async_ps", period_start, 0);
    check("async_fault", fault, 0);
    st_m = M_IDLE; pend_m = 0; prev_comp = 1'b0; computed = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    check("post_reset_duty", duty, 0);
    check("post_reset_heater", heater_on, 0);
    tick();
    run_period('0, 1, 1, 1'b0);
    run_period('0, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
